cdb_arbiter: RTL

Transmit end of the common data bus (CDB). It collects completed results (ROB tag plus value) from the functional units and broadcasts exactly one result per cycle on `cdb_valid` / `cdb_rob_tag` / `cdb_data`, the bus every reservation station and the ROB snoop. Each source has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter picks which held result drives the registered bus in the next cycle.

---
 rtl/cdb_pkg.sv | 24 ++
 rtl/round_robin_arbiter.sv | 44 ++++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB). The CDB transmit end
// (cdb_arbiter), the reservation stations and the ROB all agree on these
// widths and on the broadcast packet layout.
//
// Contents:
//   CDB_XLEN, CDB_TAG_WIDTH, CDB_N_SOURCES : default bus geometry
//   cdb_packet                             : {valid, rob_tag, data} broadcast
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int CDB_XLEN      = 32;
  localparam int CDB_TAG_WIDTH = 32;
  localparam int CDB_N_SOURCES = 4;

  // One broadcast beat as seen by every snooper of the bus.
  typedef struct packed {
    logic                     valid;
    logic [CDB_TAG_WIDTH-1:0] rob_tag;
    logic [CDB_XLEN-1:0]      data;
  } cdb_packet;

endpackage

// File: rtl/round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
// Purely combinational rotating-priority arbiter. The scan starts at index
// `ptr` and wraps modulo N; the first asserted request wins.
//
// Ports:
//   request     in  N      : request vector
//   ptr         in  PW     : highest-priority index for this cycle
//   grant       out N      : one-hot grant (all zero when nothing requests)
//   grant_valid out 1      : some request was granted
//   grant_index out PW     : index of the granted request (0 when none)
// -----------------------------------------------------------------------------
module round_robin_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [PW-1:0] grant_index
);

  int idx;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned; otherwise synthesis would infer latches.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_index = '0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      // Explicit modulo so non-power-of-two N wraps correctly.
      idx = (int'(ptr) + k) % N;
      if (!grant_valid && request[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
        grant_index = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Transmit end of the common data bus. Each functional unit owns a one-entry
// holding buffer with a valid/ready handshake; a round-robin arbiter picks
// one held result per cycle and it is broadcast from registered outputs in
// the following cycle.
//
// Ports:
//   clk          in  1                 : clock, rising edge
//   reset        in  1                 : synchronous, active-high
//   flush        in  1                 : drop all buffered / in-flight results
//   fu_valid     in  N_SOURCES         : source i presents a result
//   fu_rob_tag   in  N_SOURCES*TAG_WIDTH : ROB tag per source (source i at i*TAG_WIDTH)
//   fu_data      in  N_SOURCES*XLEN    : result value per source (source i at i*XLEN)
//   fu_ready     out N_SOURCES         : buffer i accepts this cycle (combinational)
//   cdb_valid    out 1                 : broadcast valid (registered)
//   cdb_rob_tag  out TAG_WIDTH         : broadcast tag (registered)
//   cdb_data     out XLEN              : broadcast value (registered)
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int XLEN      = CDB_XLEN,
  parameter  int TAG_WIDTH = CDB_TAG_WIDTH,
  parameter  int N_SOURCES = CDB_N_SOURCES,
  localparam int PTR_W     = $clog2(N_SOURCES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [N_SOURCES-1:0]           fu_valid,
  input  logic [N_SOURCES*TAG_WIDTH-1:0] fu_rob_tag,
  input  logic [N_SOURCES*XLEN-1:0]      fu_data,
  output logic [N_SOURCES-1:0]           fu_ready,
  output logic                           cdb_valid,
  output logic [TAG_WIDTH-1:0]           cdb_rob_tag,
  output logic [XLEN-1:0]                cdb_data
);

  // Same layout as cdb_packet, sized by this instance's parameters.
  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] rob_tag;
    logic [XLEN-1:0]      data;
  } bus_t;

  logic [N_SOURCES-1:0]                held;
  logic [N_SOURCES-1:0][TAG_WIDTH-1:0] tag_buf;
  logic [N_SOURCES-1:0][XLEN-1:0]      data_buf;
  logic [PTR_W-1:0]                    rr_ptr;
  bus_t                                cdb_q;

  logic [N_SOURCES-1:0] grant;
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_index;
  logic [N_SOURCES-1:0] accept;
  logic [PTR_W-1:0]     next_ptr;

  round_robin_arbiter #(.N(N_SOURCES)) u_rr (
    .request     (held),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  // A granted buffer drains at this edge, so it can take a new result in the
  // same cycle; that is what lets one source stream at full rate.
  assign fu_ready = (~held | grant) & {N_SOURCES{~(reset | flush)}};
  assign accept   = fu_valid & fu_ready;

  assign next_ptr = (grant_index == PTR_W'(N_SOURCES - 1)) ? '0
                                                           : grant_index + PTR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      held   <= '0;
      rr_ptr <= '0;
      cdb_q  <= '0;
    end else if (flush) begin
      held  <= '0;
      cdb_q <= '0;
    end else begin
      for (int i = 0; i < N_SOURCES; i++) begin
        // A new accept wins over the grant-clear: the buffer reloads.
        if (accept[i])     held[i] <= 1'b1;
        else if (grant[i]) held[i] <= 1'b0;
      end
      if (grant_valid) begin
        cdb_q.valid   <= 1'b1;
        cdb_q.rob_tag <= tag_buf[grant_index];
        cdb_q.data    <= data_buf[grant_index];
        rr_ptr        <= next_ptr;
      end else begin
        cdb_q <= '0;
      end
    end
  end

  // NOTE: the payload buffers carry no reset; `held` alone says whether an
  // entry is meaningful, and accept is already blocked during reset/flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SOURCES; i++) begin
      if (accept[i]) begin
        tag_buf[i]  <= fu_rob_tag[i*TAG_WIDTH +: TAG_WIDTH];
        data_buf[i] <= fu_data[i*XLEN +: XLEN];
      end
    end
  end

  assign cdb_valid   = cdb_q.valid;
  assign cdb_rob_tag = cdb_q.rob_tag;
  assign cdb_data    = cdb_q.data;

endmodule
